// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: output-mode encoding
// and the two-state control FSM encoding.
package clkdiv_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic mode_is_toggle(input logic mode);
        return (mode == MODE_TOGGLE);
    endfunction

endpackage

// File: rtl/div_counter_core.sv
// Loadable down-counter with a terminal-count flag; clear has priority over
// load, and load over decrement, so a reload always wins at count zero.
module div_counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Decrement stops at zero, so the counter can never wrap to full scale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider producing a per-period tick and a divided
// clock (toggle or pulse), with shadowed loads applied only at period boundaries.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int unsigned RESET_DIV  = 1,
    parameter bit          RESET_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] par_load,
    input  logic             mode_in,
    output logic             ld_ack,
    output logic             pend,
    output logic             tick,
    output logic             clk_div
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] div_active, div_nxt;
    logic             mode_active, mode_nxt;
    logic [WIDTH-1:0] shadow_div, shadow_div_nxt;
    logic             shadow_mode, shadow_mode_nxt;
    logic             pend_nxt, ld_ack_nxt, tick_nxt, clk_div_nxt;

    logic             apply;
    logic [WIDTH-1:0] new_div;
    logic             new_mode;

    logic             cnt_clear, cnt_load, cnt_dec, cnt_tc;
    logic [WIDTH-1:0] cnt_load_value, cnt_value;

    div_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .tc         (cnt_tc)
    );

    // A load on this very edge beats a pending shadow value (last value wins).
    always_comb begin
        apply    = 1'b0;
        new_div  = div_active;
        new_mode = mode_active;
        if (ld) begin
            apply    = 1'b1;
            new_div  = par_load;
            new_mode = mode_in;
        end else if (pend) begin
            apply    = 1'b1;
            new_div  = shadow_div;
            new_mode = shadow_mode;
        end
    end

    always_comb begin
        state_nxt       = state;
        div_nxt         = div_active;
        mode_nxt        = mode_active;
        shadow_div_nxt  = shadow_div;
        shadow_mode_nxt = shadow_mode;
        pend_nxt        = pend;
        ld_ack_nxt      = 1'b0;
        tick_nxt        = 1'b0;
        clk_div_nxt     = clk_div;
        cnt_clear       = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_value  = '0;
        cnt_dec         = 1'b0;

        case (state)
            IDLE: begin
                clk_div_nxt = 1'b0;
                if (apply) begin
                    div_nxt    = new_div;
                    mode_nxt   = new_mode;
                    ld_ack_nxt = 1'b1;
                    pend_nxt   = 1'b0;
                end
                if (en && (new_div != '0)) begin
                    state_nxt      = RUN;
                    cnt_load       = 1'b1;
                    cnt_load_value = new_div - ONE;
                end
            end

            RUN: begin
                if (!en) begin
                    state_nxt   = IDLE;
                    cnt_clear   = 1'b1;
                    clk_div_nxt = 1'b0;
                    if (ld) begin
                        shadow_div_nxt  = par_load;
                        shadow_mode_nxt = mode_in;
                        pend_nxt        = 1'b1;
                    end
                end else if (cnt_tc) begin
                    if (apply) begin
                        div_nxt    = new_div;
                        mode_nxt   = new_mode;
                        ld_ack_nxt = 1'b1;
                        pend_nxt   = 1'b0;
                    end
                    if (new_div == '0) begin
                        state_nxt   = IDLE;
                        cnt_clear   = 1'b1;
                        clk_div_nxt = 1'b0;
                    end else begin
                        tick_nxt       = 1'b1;
                        cnt_load       = 1'b1;
                        cnt_load_value = new_div - ONE;
                        // A mode change restarts the output low instead of toggling.
                        if (new_mode != mode_active) begin
                            clk_div_nxt = 1'b0;
                        end else if (mode_is_toggle(new_mode)) begin
                            clk_div_nxt = ~clk_div;
                        end else begin
                            clk_div_nxt = 1'b1;
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                    if (!mode_is_toggle(mode_active)) begin
                        clk_div_nxt = 1'b0;
                    end
                    if (ld) begin
                        shadow_div_nxt  = par_load;
                        shadow_mode_nxt = mode_in;
                        pend_nxt        = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            div_active  <= WIDTH'(RESET_DIV);
            mode_active <= RESET_MODE;
            shadow_div  <= '0;
            shadow_mode <= MODE_PULSE;
            pend        <= 1'b0;
            ld_ack      <= 1'b0;
            tick        <= 1'b0;
            clk_div     <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_active  <= div_nxt;
            mode_active <= mode_nxt;
            shadow_div  <= shadow_div_nxt;
            shadow_mode <= shadow_mode_nxt;
            pend        <= pend_nxt;
            ld_ack      <= ld_ack_nxt;
            tick        <= tick_nxt;
            clk_div     <= clk_div_nxt;
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: an 8-bit instance for load/mode
// behaviour and a 4-bit full-scale instance for reset-mid-period behaviour.
module tb_prog_clock_divider;

    logic       clk;
    logic       rst, en, ld, mode_in;
    logic [7:0] par_load;
    logic       ld_ack, pend, tick, clk_div;

    logic       rst4, en4, ld4, mode4;
    logic [3:0] par4;
    logic       ld_ack4, pend4, tick4, clk_div4;

    int checks = 0;
    int errors = 0;

    prog_clock_divider #(.WIDTH(8), .RESET_DIV(1), .RESET_MODE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ld       (ld),
        .par_load (par_load),
        .mode_in  (mode_in),
        .ld_ack   (ld_ack),
        .pend     (pend),
        .tick     (tick),
        .clk_div  (clk_div)
    );

    prog_clock_divider #(.WIDTH(4), .RESET_DIV(15), .RESET_MODE(1'b0)) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .en       (en4),
        .ld       (ld4),
        .par_load (par4),
        .mode_in  (mode4),
        .ld_ack   (ld_ack4),
        .pend     (pend4),
        .tick     (tick4),
        .clk_div  (clk_div4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic l, input logic [7:0] p, input logic m);
        ld       = l;
        par_load = p;
        mode_in  = m;
        @(posedge clk);
        #1;
        ld       = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ld = 1'b0; par_load = '0; mode_in = 1'b0;
        rst4 = 1'b0; en4 = 1'b0; ld4 = 1'b0; par4 = '0; mode4 = 1'b0;
        #12;
        checkOutput("reset8", {ld_ack, tick, pend, clk_div}, 4'b0000);
        checkOutput("reset4", {ld_ack4, tick4, pend4, clk_div4}, 4'b0000);
        rst = 1'b1;
        rst4 = 1'b1;

        // IDLE load of N=4 toggle, then run
        applyStimulus(1'b1, 8'd4, 1'b1);
        checkOutput("idle_ld_ack", {ld_ack, pend}, 2'b10);
        en = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("run_entry", {ld_ack, tick, clk_div}, 3'b000);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("n4_c%0d", i), {tick, clk_div}, {(i % 4 == 0), ((i / 4) % 2 == 1)});
        end

        // Mid-period load of 6 waits for the boundary
        for (int p = 1; p <= 4; p++) begin
            applyStimulus(p == 1, 8'd6, 1'b1);
            checkOutput($sformatf("shadow6_c%0d", p), {ld_ack, tick, pend, clk_div}, (p < 4) ? 4'b0011 : 4'b1100);
        end
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("n6_c%0d", j), {tick, clk_div},
                        {(j == 6 || j == 12), (j >= 6 && j < 12)});
        end

        // Two loads in one period: only the last (5) is applied, one ack
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(k == 1 || k == 3, (k == 1) ? 8'd3 : 8'd5, 1'b1);
            checkOutput($sformatf("dbl_ld_c%0d", k), {ld_ack, tick, pend},
                        {(k == 6), (k == 6 || k == 11), (k <= 5)});
        end

        // Switch to N=1 pulse mode: tick and clk_div go continuous
        for (int m = 1; m <= 10; m++) begin
            applyStimulus(m == 1, 8'd1, 1'b0);
            checkOutput($sformatf("n1_c%0d", m), {ld_ack, tick, pend, clk_div},
                        (m <= 4) ? 4'b0010 : ((m == 5) ? 4'b1100 : 4'b0101));
        end

        // Load on a terminal-count edge: N=2 toggle, restarts low
        applyStimulus(1'b1, 8'd2, 1'b1);
        checkOutput("tc_ld", {ld_ack, tick, pend, clk_div}, 4'b1100);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("n2_c%0d", j), {tick, clk_div}, {(j % 2 == 0), ((j / 2) % 2 == 1)});
        end

        // Divisor 0 idles at the boundary
        for (int q = 1; q <= 5; q++) begin
            applyStimulus(q == 1, 8'd0, 1'b1);
            checkOutput($sformatf("div0_c%0d", q), {ld_ack, tick, pend, clk_div},
                        (q == 1) ? 4'b0010 : ((q == 2) ? 4'b1000 : 4'b0000));
        end
        applyStimulus(1'b1, 8'd3, 1'b1);
        checkOutput("resume_ack", {ld_ack, tick, pend, clk_div}, 4'b1000);
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("resume_c%0d", r), {tick, clk_div}, (r == 3) ? 2'b11 : 2'b00);
        end
        en = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("en_low", {ld_ack, tick, pend, clk_div}, 4'b0000);

        // 4-bit full-scale N=15 pulse mode
        en4 = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("fs_entry", {tick4, clk_div4}, 2'b00);
        for (int j = 1; j <= 20; j++) begin
            ld4  = (j == 17);
            par4 = 4'd5;
            applyStimulus(1'b0, 8'd0, 1'b0);
            ld4  = 1'b0;
            checkOutput($sformatf("fs_c%0d", j), {tick4, clk_div4, pend4}, {(j == 15), (j == 15), (j >= 17)});
        end

        // Reset mid-period drops outputs and discards the pending load
        #2 rst4 = 1'b0;
        #1;
        checkOutput("fs_rst", {ld_ack4, tick4, pend4, clk_div4}, 4'b0000);
        #4 rst4 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("fs_reentry", {ld_ack4, tick4, pend4}, 3'b000);
        for (int j = 1; j <= 15; j++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("fs_post_c%0d", j), {tick4, clk_div4}, (j == 15) ? 2'b11 : 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Parametrised successor to the 8-bit fixed-terminal-count divider.
- Divides clk by a runtime-programmable divisor N of WIDTH bits and produces two outputs:
  - a one-cycle tick every N cycles;
  - a divided clock that is either a 50% toggle (period 2N) or a pulse train, selected per load.
- A shadow register makes divisor and mode changes glitch-free: they take effect only at a period boundary.
- Sits beside the waveform/function-generator datapath as its sample-rate enable source.

Parameters:
- WIDTH, 8, width of divisor and internal counter.
- RESET_DIV, 1, active divisor after reset; 0 means the block starts in IDLE.
- RESET_MODE, 1, active mode after reset: 1 = toggle, 0 = pulse.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable, level-sensitive.
- ld  in  1  load request; captures par_load and mode_in on the edge it is sampled high.
- par_load  in  WIDTH  new divisor N.
- mode_in  in  1  new mode, captured with ld.
- ld_ack  out  1  one-cycle pulse when a load becomes active.
- pend  out  1  a captured load is waiting for the next boundary.
- tick  out  1  one-cycle pulse per completed period.
- clk_div  out  1  divided clock output.

Behaviour:
- Reset (rst low, asynchronous):
  - div_active=RESET_DIV, mode_active=RESET_MODE, count=0, pend=0.
  - ld_ack=0, tick=0, clk_div=0, state=IDLE.
- State machine has two states, IDLE and RUN.
- IDLE → RUN: on the first edge where en=1 and the effective divisor is nonzero.
  - Effective divisor is par_load if ld=1 on that edge, else div_active.
  - At that edge, count is loaded with (divisor−1).
- RUN → IDLE: on the edge where en is sampled 0.
  - At that edge, count=0, tick=0, clk_div=0 and pend is kept.
- Counting in RUN:
  - count decrements by 1 each edge.
  - Terminal count is count==0 sampled at an edge. On that edge: tick<=1, count reloads (div_next−1), and in toggle mode clk_div<=~clk_div.
  - Pulse mode: clk_div equals tick, registered identically.
- Latency: first tick is high for the cycle after the Nth edge following the RUN-entry edge. Subsequent ticks repeat every N cycles.
- N=1: tick stays high continuously. Toggle mode then gives period 2.
- Loads while in IDLE:
  - div_active/mode_active are updated on the same edge.
  - ld_ack pulses the next cycle and pend stays 0.
- Loads while in RUN, not at terminal count:
  - Value is stored in the shadow register and pend<=1.
  - At the next terminal count: div_next=shadow, mode_active updated, pend<=0, and ld_ack pulses coincident with tick.
- Load on a terminal-count edge: applied directly in that reload. ld_ack and tick pulse together and pend stays 0.
- Repeated ld while pend=1: the last value wins. Only one ld_ack is issued, for the value actually applied.
- Divisor 0 becoming active (IDLE load or boundary apply):
  - Block enters/stays in IDLE, tick=0, clk_div=0.
  - ld_ack still pulses.
  - The block remains idle until a nonzero load arrives with en=1.
- Mode change at a boundary: clk_div is forced to 0 on that edge, with no extra toggle, so toggle mode restarts low.
- en low with pend=1: the pending value is applied at the next IDLE edge, with ld_ack.
- Counter never wraps: the reload always precedes decrement below 0. Full-scale N=2^WIDTH−1 must work.
- Reset mid-period: outputs drop immediately and the pending load is discarded.

Decomposition:
- Shared package (clkdiv_pkg):
  - mode encoding constants MODE_PULSE=0, MODE_TOGGLE=1;
  - state encoding IDLE/RUN.
- One natural sub-module: div_counter_core. It contains the loadable down-counter with terminal-count flag and reload input, parametrised by WIDTH.
- Shadow register, FSM and output shaping stay in the top module.

Test Plan:
- Reset with RESET_DIV=1, en=0; ld par_load=4 mode=1; en=1 → ld_ack 1 cycle; tick every 4 cycles; clk_div period 8, 50% duty.
- Running N=4 toggle; ld par_load=6 mid-period → pend=1 until boundary; ld_ack coincident with tick; next period 6 cycles, no short or long pulse on clk_div.
- Two lds (3 then 5) within one period → single ld_ack; applied period is 5.
- N=1 pulse mode → tick and clk_div high continuously. Switch to N=2 toggle → clk_div period 4, starting low.
- ld par_load=0 while running → block idles at boundary, tick=0, clk_div=0; later ld 3 → RUN resumes, first tick 3 cycles later.
- WIDTH=4, N=15; assert rst low mid-period → all outputs 0 immediately, pend=0. After release with en=1 → first tick 15 cycles after RESET_DIV reload.
